// File: rtl/sync_fifo_param_if.sv
// Bundle of the sync_fifo_param request/response signals; the producer/consumer side
// uses the master modport and the FIFO uses slave. parity_err exists only with SYNC_FIFO_PARITY_EN.
interface sync_fifo_param_if #(
    parameter int DATA_WIDTH       = 8,
    parameter int FIFO_DEPTH_WIDTH = 5
);
    logic                        clear;
    logic                        write;
    logic [DATA_WIDTH-1:0]       data_write;
    logic                        read;
    logic [DATA_WIDTH-1:0]       data_read;
    logic                        full;
    logic                        empty;
    logic                        almost_full;
    logic                        almost_empty;
    logic [FIFO_DEPTH_WIDTH:0]   data_count;
    logic                        overflow;
    logic                        underflow;
`ifdef SYNC_FIFO_PARITY_EN
    logic                        parity_err;
`endif

    modport master (
        output clear, write, data_write, read,
        input  data_read, full, empty, almost_full, almost_empty, data_count,
               overflow, underflow
`ifdef SYNC_FIFO_PARITY_EN
        , parity_err
`endif
    );

    modport slave (
        input  clear, write, data_write, read,
        output data_read, full, empty, almost_full, almost_empty, data_count,
               overflow, underflow
`ifdef SYNC_FIFO_PARITY_EN
        , parity_err
`endif
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with optional FWFT output, programmable almost flags,
// synchronous flush and sticky overflow/underflow. Define SYNC_FIFO_PARITY_EN for RAM parity checking.
module sync_fifo_param #(
    parameter int DATA_WIDTH       = 8,
    parameter int FIFO_DEPTH_WIDTH = 5,
    parameter int FWFT             = 0,
    parameter int AF_LEVEL         = 28,
    parameter int AE_LEVEL         = 4
) (
    input  logic              clk,
    input  logic              rst,
    sync_fifo_param_if.slave  fifo
);
    localparam int DEPTH = 1 << FIFO_DEPTH_WIDTH;
    localparam int CW    = FIFO_DEPTH_WIDTH + 1;
`ifdef SYNC_FIFO_PARITY_EN
    localparam int RAM_W = DATA_WIDTH + 1;
`else
    localparam int RAM_W = DATA_WIDTH;
`endif

    // Threshold sanity is enforced while elaborating so a bad instance never builds.
    generate
        if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
            $fatal(1, "sync_fifo_param: AF_LEVEL must be within 1..depth");
        end
        if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
            $fatal(1, "sync_fifo_param: AE_LEVEL must be within 0..depth-1");
        end
    endgenerate

    logic [RAM_W-1:0]      mem [DEPTH];
    logic [RAM_W-1:0]      wr_word;
    logic [RAM_W-1:0]      rd_word;
    logic [CW-1:0]         wr_ptr;
    logic [CW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_next;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  full_q;
    logic                  empty_q;
    logic                  af_q;
    logic                  ae_q;
    logic                  ovf_q;
    logic                  udf_q;
    logic                  flush;
    logic                  rd_ok;
    logic                  wr_ok;
    logic                  ram_rd;
    logic                  empty_next;
`ifdef SYNC_FIFO_PARITY_EN
    logic                  perr_q;
`endif

    assign flush = rst | fifo.clear;
    assign rd_ok = fifo.read & ~empty_q;
    assign wr_ok = fifo.write & (~full_q | rd_ok);

`ifdef SYNC_FIFO_PARITY_EN
    assign wr_word = {^fifo.data_write, fifo.data_write};
`else
    assign wr_word = fifo.data_write;
`endif
    assign rd_word = mem[rd_ptr[FIFO_DEPTH_WIDTH-1:0]];

    always_comb begin
        count_next = count;
        case ({wr_ok, rd_ok})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    generate
        if (FWFT == 0) begin : g_std
            assign ram_rd     = rd_ok;
            assign empty_next = (count_next == '0);
        end else begin : g_fwft
            // The output register holds the head word; the RAM refills it whenever it is
            // empty or being popped, which is what keeps back-to-back reads bubble-free.
            logic dout_valid;
            logic dout_valid_next;
            logic ram_has;

            assign ram_has         = (wr_ptr != rd_ptr);
            assign ram_rd          = ram_has & (~dout_valid | rd_ok);
            assign dout_valid_next = ram_rd | (dout_valid & ~rd_ok);
            assign empty_next      = ~dout_valid_next;

            always_ff @(posedge clk) begin
                if (flush) begin
                    dout_valid <= 1'b0;
                end else begin
                    dout_valid <= dout_valid_next;
                end
            end
        end
    endgenerate

    // The RAM is never cleared; flush only blocks the write of that cycle.
    always_ff @(posedge clk) begin
        if (wr_ok && !flush) begin
            mem[wr_ptr[FIFO_DEPTH_WIDTH-1:0]] <= wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            dout_q  <= '0;
            empty_q <= 1'b1;
            ae_q    <= 1'b1;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + CW'(1);
            end
            if (ram_rd) begin
                rd_ptr <= rd_ptr + CW'(1);
                dout_q <= rd_word[DATA_WIDTH-1:0];
            end
            if (fifo.write && !wr_ok) begin
                ovf_q <= 1'b1;
            end
            if (fifo.read && !rd_ok) begin
                udf_q <= 1'b1;
            end
            count   <= count_next;
            empty_q <= empty_next;
            full_q  <= (count_next == CW'(DEPTH));
            af_q    <= (count_next >= CW'(AF_LEVEL));
            ae_q    <= (count_next <= CW'(AE_LEVEL));
        end
    end

`ifdef SYNC_FIFO_PARITY_EN
    // The error flag travels with the word in the output register.
    always_ff @(posedge clk) begin
        if (flush) begin
            perr_q <= 1'b0;
        end else if (ram_rd) begin
            perr_q <= ^rd_word;
        end else if (rd_ok) begin
            perr_q <= 1'b0;
        end
    end
    assign fifo.parity_err = perr_q;
`endif

    assign fifo.data_read    = dout_q;
    assign fifo.full         = full_q;
    assign fifo.empty        = empty_q;
    assign fifo.almost_full  = af_q;
    assign fifo.almost_empty = ae_q;
    assign fifo.data_count   = count;
    assign fifo.overflow     = ovf_q;
    assign fifo.underflow    = udf_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: a standard-mode instance checked each cycle against a
// queue model, and an FWFT instance checked at its latency and underflow corner cases.
module tb_sync_fifo_param;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic       exp_ovf;
    logic       exp_udf;
    logic [7:0] exp_dout;

    always #5 clk = ~clk;

    sync_fifo_param_if #(.DATA_WIDTH(8), .FIFO_DEPTH_WIDTH(5)) bus0 ();
    sync_fifo_param_if #(.DATA_WIDTH(8), .FIFO_DEPTH_WIDTH(5)) bus1 ();

    sync_fifo_param #(
        .DATA_WIDTH(8), .FIFO_DEPTH_WIDTH(5), .FWFT(0), .AF_LEVEL(28), .AE_LEVEL(4)
    ) dut0 (
        .clk(clk), .rst(rst), .fifo(bus0)
    );

    sync_fifo_param #(
        .DATA_WIDTH(8), .FIFO_DEPTH_WIDTH(5), .FWFT(1), .AF_LEVEL(28), .AE_LEVEL(4)
    ) dut1 (
        .clk(clk), .rst(rst), .fifo(bus1)
    );

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of the standard-mode instance; the queue model predicts the outcome.
    task automatic apply_stimulus(input logic w, input logic [7:0] d, input logic r,
                                  input logic clr, input logic rs);
        logic rd_ok;
        logic wr_ok;
        bus0.write      = w;
        bus0.data_write = d;
        bus0.read       = r;
        bus0.clear      = clr;
        rst             = rs;
        @(posedge clk);
        rd_ok = r && (q0.size() != 0);
        wr_ok = w && ((q0.size() < 32) || rd_ok);
        if (rs || clr) begin
            q0.delete();
            exp_ovf  = 1'b0;
            exp_udf  = 1'b0;
            exp_dout = 8'h00;
        end else begin
            if (rd_ok) exp_dout = q0.pop_front();
            if (wr_ok) q0.push_back(d);
            if (w && !wr_ok) exp_ovf = 1'b1;
            if (r && !rd_ok) exp_udf = 1'b1;
        end
        #1;
        check_output("count",     bus0.data_count,   q0.size());
        check_output("full",      bus0.full,         q0.size() == 32);
        check_output("empty",     bus0.empty,        q0.size() == 0);
        check_output("af",        bus0.almost_full,  q0.size() >= 28);
        check_output("ae",        bus0.almost_empty, q0.size() <= 4);
        check_output("overflow",  bus0.overflow,     exp_ovf);
        check_output("underflow", bus0.underflow,    exp_udf);
        check_output("data_read", bus0.data_read,    exp_dout);
    endtask

    task automatic step1(input logic w, input logic [7:0] d, input logic r, input logic clr);
        bus1.write      = w;
        bus1.data_write = d;
        bus1.read       = r;
        bus1.clear      = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [7:0] head;
        bus0.write = 0; bus0.read = 0; bus0.clear = 0; bus0.data_write = 0;
        bus1.write = 0; bus1.read = 0; bus1.clear = 0; bus1.data_write = 0;
        rst = 1'b1;
        exp_ovf = 0; exp_udf = 0; exp_dout = 0;

        $display("[TB] reset");
        apply_stimulus(0, 8'h00, 0, 0, 1);
        check_output("fwft_rst_empty", bus1.empty, 1);
        check_output("fwft_rst_count", bus1.data_count, 0);
        check_output("fwft_rst_ae",    bus1.almost_empty, 1);
        check_output("fwft_rst_dout",  bus1.data_read, 0);

        $display("[TB] fill");
        for (int i = 0; i <= 40; i++) apply_stimulus(1, 8'(i), 0, 0, 0);
        check_output("fill_full", bus0.full, 1);
        check_output("fill_ovf",  bus0.overflow, 1);

        $display("[TB] drain");
        for (int i = 0; i < 40; i++) apply_stimulus(0, 8'h00, 1, 0, 0);
        check_output("drain_udf", bus0.underflow, 1);

        $display("[TB] concurrent while full");
        for (int i = 0; i < 32; i++) apply_stimulus(1, 8'(8'h40 + i), 0, 0, 0);
        for (int i = 0; i < 10; i++) apply_stimulus(1, 8'(100 + i), 1, 0, 0);
        for (int i = 0; i < 42; i++) apply_stimulus(0, 8'h00, 1, 0, 0);

        $display("[TB] clear mid-operation");
        for (int i = 0; i < 17; i++) apply_stimulus(1, 8'(8'h80 + i), 0, 0, 0);
        apply_stimulus(1, 8'hEE, 1, 1, 0);
        apply_stimulus(0, 8'h00, 0, 0, 0);

        $display("[TB] wrap");
        for (int rnd = 0; rnd < 5; rnd++) begin
            for (int i = 0; i < 20; i++) apply_stimulus(1, 8'(rnd * 20 + i), 0, 0, 0);
            for (int i = 0; i < 20; i++) apply_stimulus(0, 8'h00, 1, 0, 0);
        end
        bus0.write = 0; bus0.read = 0; bus0.clear = 0;

        $display("[TB] fwft");
        step1(1, 8'hA5, 0, 0);
        q1.push_back(8'hA5);
        check_output("fwft_empty_lag", bus1.empty, 1);
        check_output("fwft_count1",    bus1.data_count, 1);
        step1(0, 8'h00, 0, 0);
        check_output("fwft_empty_fall", bus1.empty, 0);
        check_output("fwft_head",       bus1.data_read, q1[0]);
        for (int i = 0; i < 3; i++) begin
            step1(1, 8'(8'hB1 + i), 0, 0);
            q1.push_back(8'(8'hB1 + i));
        end
        check_output("fwft_count4", bus1.data_count, 4);
        for (int i = 0; i < 4; i++) begin
            head = q1.pop_front();
            check_output("fwft_valid", bus1.empty, 0);
            check_output("fwft_word",  bus1.data_read, head);
            step1(0, 8'h00, 1, 0);
        end
        check_output("fwft_empty_end", bus1.empty, 1);
        check_output("fwft_count0",    bus1.data_count, 0);
        check_output("fwft_udf_clean", bus1.underflow, 0);
        step1(0, 8'h00, 1, 0);
        check_output("fwft_udf", bus1.underflow, 1);
        step1(0, 8'h00, 0, 1);
        check_output("fwft_clr_udf",   bus1.underflow, 0);
        check_output("fwft_clr_empty", bus1.empty, 1);
        step1(1, 8'h3C, 1, 0);
        q1.push_back(8'h3C);
        check_output("fwft_nopass_udf",   bus1.underflow, 1);
        check_output("fwft_nopass_count", bus1.data_count, 1);
        check_output("fwft_nopass_empty", bus1.empty, 1);
        step1(0, 8'h00, 0, 0);
        head = q1.pop_front();
        check_output("fwft_late_empty", bus1.empty, 0);
        check_output("fwft_late_word",  bus1.data_read, head);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
